gelato_l1_fill_responder: RTL
=============================

GELATO_L1_FILL_RESPONDER -- requirements
Module: gelato_l1_fill_responder

Interface
REQ-001 Parameter LINE_WORDS, default 4, number of 32-bit data_t words per L1 cache line; L1_CACHE_LINE_SIZE SHALL equal 32*LINE_WORDS.
REQ-002 Parameter ID_WIDTH, default 2, width of requester tag.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 fill_req_valid  input  1  L1 miss request valid.
REQ-006 fill_req_ready  output  1  responder can accept request.
REQ-007 fill_req_addr  input  addr_t  miss address (any byte within line).
REQ-008 fill_req_id  input  ID_WIDTH  requester tag.
REQ-009 fill_rsp_valid  output  1  filled line valid.
REQ-010 fill_rsp_ready  input  1  L1 accepts line.
REQ-011 fill_rsp_tag  output  l1_cache_tag_t  tag field of the line address.
REQ-012 fill_rsp_data  output  l1_cache_line_t  assembled line; word i at bits [32i+31:32i].
REQ-013 fill_rsp_id  output  ID_WIDTH  echoed requester tag.
REQ-014 mem_req_valid  output  1  word read request to memory.
REQ-015 mem_req_ready  input  1  memory accepts word request.
REQ-016 mem_req_addr  output  addr_t  word address.
REQ-017 mem_rsp_valid  input  1  read data valid (in order, one per accepted request).
REQ-018 mem_rsp_data  input  data_t  read data word.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 fill_req_ready SHALL be 1 exactly in IDLE; a request is accepted when fill_req_valid && fill_req_ready.
REQ-021 On accept: latch base = fill_req_addr with low log2(4*LINE_WORDS) bits cleared, latch id, clear word counter, clear line buffer, go to ISSUE.
REQ-022 ISSUE: mem_req_valid=1, mem_req_addr = base + 4*counter; on mem_req_ready go WAIT; otherwise hold valid and address stable.
REQ-023 WAIT: mem_req_valid=0; on mem_rsp_valid write mem_rsp_data into word[counter]; if counter==LINE_WORDS-1 go RESP, else counter+1 and go ISSUE.
REQ-024 mem_rsp_valid in IDLE, ISSUE, or RESP SHALL be ignored (no state change).
REQ-025 RESP: fill_rsp_valid=1 with data, tag, id stable; on fill_rsp_ready go IDLE; fill_req_ready stays 0 until the cycle after the handshake.
REQ-026 fill_rsp_tag SHALL be the L1_CACHE_TAG_INDEX bits of base.
REQ-027 Counter width SHALL be clog2(LINE_WORDS); no wrap occurs since RESP is entered at LINE_WORDS-1.
REQ-028 Latency with mem_req_ready=1 and mem_rsp_valid one cycle after request: fill_rsp_valid first high 1+2*LINE_WORDS cycles after accept cycle.
REQ-029 Only one fill outstanding; no request queueing.
REQ-030 Address arithmetic is modulo 2^ADDR width; line base never crosses a line boundary.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counter 0, line buffer 0, latched base/id 0.
REQ-032 Reset outputs: fill_req_ready=0 while rst_n low, 1 on the first cycle after release; fill_rsp_valid=0, mem_req_valid=0, all data/addr/tag/id outputs 0.
REQ-033 Reset mid-fill SHALL abandon the fill; late mem_rsp_valid after release SHALL be ignored per REQ-024.

Structure
REQ-034 addr_t, data_t, l1_cache_tag_t, l1_cache_line_t and the FSM state enum SHALL come from / be added to the shared gelato_types package; index macros from gelato_macros.
REQ-035 Single flat module; no sub-modules.

Verification
REQ-036 Req addr 0x0000_1004, id 2, mem always ready, 1-cycle data 0xA0,0xA1,0xA2,0xA3 -> mem addrs 0x1000,0x1004,0x1008,0x100C; rsp data {0xA3,0xA2,0xA1,0xA0}, id 2, valid at accept+9.
REQ-037 mem_req_ready low 3 cycles in ISSUE -> mem_req_valid/addr held stable; fill completes with correct data.
REQ-038 fill_rsp_ready low 5 cycles -> rsp held stable, fill_req_ready 0; new request accepted only after handshake.
REQ-039 Spurious mem_rsp_valid in IDLE and in ISSUE -> no state/data change.
REQ-040 rst_n asserted after word 1 of a fill -> all outputs reset immediately; next fill returns fresh data only.
REQ-041 Two back-to-back requests with fill_req_valid held -> second accepted the cycle after first response handshake.

Source files
------------

// File: rtl/gelato_types.sv
// Shared Gelato address/data/L1 line types and the fill-responder FSM state encoding.
// L1 geometry: byte offset within the line, then set index, then tag.
package gelato_types;

   localparam int ADDR_W             = 32;
   localparam int DATA_W             = 32;
   localparam int L1_LINE_WORDS      = 4;
   localparam int L1_CACHE_LINE_SIZE = DATA_W * L1_LINE_WORDS;
   localparam int L1_OFFSET_BITS     = $clog2(4 * L1_LINE_WORDS);
   localparam int L1_INDEX_BITS      = 6;
   localparam int L1_TAG_LSB         = L1_OFFSET_BITS + L1_INDEX_BITS;
   localparam int L1_TAG_W           = ADDR_W - L1_TAG_LSB;

   typedef logic [ADDR_W-1:0]             addr_t;
   typedef logic [DATA_W-1:0]             data_t;
   typedef logic [L1_TAG_W-1:0]           l1_cache_tag_t;
   typedef logic [L1_CACHE_LINE_SIZE-1:0] l1_cache_line_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } fill_state_e;

endpackage

// File: rtl/gelato_l1_fill_responder.sv
// L1 miss fill responder: reads one cache line word-by-word from memory and returns it
// to the L1 as a single response, one fill outstanding at a time.
module gelato_l1_fill_responder
   import gelato_types::*;
#(
   parameter int  LINE_WORDS         = 4,
   parameter int  ID_WIDTH           = 2,
   localparam int L1_CACHE_LINE_SIZE = 32 * LINE_WORDS,
   localparam int OFFSET_BITS        = $clog2(4 * LINE_WORDS),
   localparam int TAG_LSB            = OFFSET_BITS + L1_INDEX_BITS,
   localparam int TAG_W              = ADDR_W - TAG_LSB
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          fill_req_valid,
   output logic                          fill_req_ready,
   input  addr_t                         fill_req_addr,
   input  logic [ID_WIDTH-1:0]           fill_req_id,
   output logic                          fill_rsp_valid,
   input  logic                          fill_rsp_ready,
   output logic [TAG_W-1:0]              fill_rsp_tag,
   output logic [L1_CACHE_LINE_SIZE-1:0] fill_rsp_data,
   output logic [ID_WIDTH-1:0]           fill_rsp_id,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output addr_t                         mem_req_addr,
   input  logic                          mem_rsp_valid,
   input  data_t                         mem_rsp_data
);

   localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
   localparam addr_t OFFSET_MASK = addr_t'(4 * LINE_WORDS - 1);

   fill_state_e                   state;
   addr_t                         base;
   logic [ID_WIDTH-1:0]           id_q;
   logic [CNT_W-1:0]              cnt;
   logic [L1_CACHE_LINE_SIZE-1:0] line;

   // Word address is always derived from the latched line base, so it cannot cross the line.
   assign mem_req_addr  = base + addr_t'({cnt, 2'b00});
   assign fill_rsp_tag  = base[ADDR_W-1:TAG_LSB];
   assign fill_rsp_data = line;
   assign fill_rsp_id   = id_q;

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         base           <= '0;
         id_q           <= '0;
         cnt            <= '0;
         // NOTE: the line buffer is small and drives an output, so it is reset like any other flop.
         line           <= '0;
         fill_req_ready <= 1'b0;
         mem_req_valid  <= 1'b0;
         fill_rsp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fill_req_valid && fill_req_ready) begin
                  base           <= fill_req_addr & ~OFFSET_MASK;
                  id_q           <= fill_req_id;
                  cnt            <= '0;
                  line           <= '0;
                  fill_req_ready <= 1'b0;
                  mem_req_valid  <= 1'b1;
                  state          <= ISSUE;
               end else begin
                  fill_req_ready <= 1'b1;
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  line[32*cnt +: 32] <= mem_rsp_data;
                  if (cnt == LAST_WORD) begin
                     fill_rsp_valid <= 1'b1;
                     state          <= RESP;
                  end else begin
                     cnt           <= cnt + 1'b1;
                     mem_req_valid <= 1'b1;
                     state         <= ISSUE;
                  end
               end
            end
            RESP: begin
               if (fill_rsp_ready) begin
                  fill_rsp_valid <= 1'b0;
                  fill_req_ready <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
